// File: rtl/svm_chain_feeder_if.sv
// Vector handshake, SV-memory/config write port and per-stage chain outputs
// of the SVM chain feeder, bundled so the feeder and its driver share one bus.
interface svm_chain_feeder_if #(
  parameter int DATA_SIZE  = 32,
  parameter int NUM_FEAT   = 2,
  parameter int NUM_SV_MAX = 16
);
  localparam int SV_AW   = $clog2(NUM_SV_MAX);
  localparam int FEAT_AW = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;

  logic                                      vec_valid;
  logic                                      vec_ready;
  logic signed [NUM_FEAT-1:0][DATA_SIZE-1:0] vec_in;
  logic                                      sv_we;
  logic        [SV_AW-1:0]                   sv_widx;
  logic        [FEAT_AW-1:0]                 sv_wfeat;
  logic signed [DATA_SIZE-1:0]               sv_wdata;
  logic                                      cfg_we;
  logic        [SV_AW:0]                     cfg_num_sv;
  logic signed [NUM_FEAT-1:0][DATA_SIZE-1:0] curr_vector_out;
  logic        [NUM_FEAT-1:0]                start_inner;
  logic        [NUM_FEAT-1:0]                last_inner;
  logic signed [NUM_FEAT-1:0][DATA_SIZE-1:0] sv_out;
  logic                                      busy;
  logic                                      done;

  modport master (
    output vec_valid, vec_in, sv_we, sv_widx, sv_wfeat, sv_wdata, cfg_we, cfg_num_sv,
    input  vec_ready, curr_vector_out, start_inner, last_inner, sv_out, busy, done
  );

  modport slave (
    input  vec_valid, vec_in, sv_we, sv_widx, sv_wfeat, sv_wdata, cfg_we, cfg_num_sv,
    output vec_ready, curr_vector_out, start_inner, last_inner, sv_out, busy, done
  );
endinterface

// File: rtl/svm_chain_feeder.sv
// Feeds one latched input vector and a skewed stream of support-vector
// elements to a NUM_FEAT-stage accumulate chain; stage k lags stage 0 by k cycles.
module svm_chain_feeder #(
  parameter int DATA_SIZE  = 32,
  parameter int NUM_FEAT   = 2,
  parameter int NUM_SV_MAX = 16
) (
  input logic               clk,
  input logic               rst,
  svm_chain_feeder_if.slave fd
);
  localparam int SV_AW = $clog2(NUM_SV_MAX);
  localparam int PW    = (NUM_FEAT > 1) ? NUM_FEAT - 1 : 1;
  localparam logic [SV_AW:0] NSV_MIN = (SV_AW+1)'(2);
  localparam logic [SV_AW:0] NSV_MAX = (SV_AW+1)'(NUM_SV_MAX);

  typedef logic [NUM_FEAT-1:0][DATA_SIZE-1:0] row_t;
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2} state_e;

  state_e                         state_q, state_d;
  logic [SV_AW-1:0]               j_q, j_d;
  logic [SV_AW:0]                 num_sv_q, last_idx;
  row_t                           vec_q;
  row_t                           mem_q [NUM_SV_MAX];
  logic [PW-1:0]                  actp_q;
  logic [PW-1:0][SV_AW-1:0]       jp_q;
  logic [NUM_FEAT-1:0]            act_s, start_s, last_s;
  logic [NUM_FEAT-1:0][SV_AW-1:0] j_s;
  row_t                           sv_s;
  logic                           idle, accept, last_j;

  assign idle     = (state_q == IDLE);
  assign accept   = idle && fd.vec_valid && !rst;
  assign last_idx = num_sv_q - 1'b1;
  assign last_j   = ({1'b0, j_q} == last_idx);

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    unique case (state_q)
      IDLE:   if (accept) begin
                state_d = STREAM;
                j_d     = '0;
              end
      STREAM: begin
                j_d = j_q + 1'b1;
                if (last_j) begin
                  j_d     = '0;
                  state_d = (NUM_FEAT > 1) ? DRAIN : IDLE;
                end
              end
      // The drain ends exactly when the last stage sees its last element.
      DRAIN:  if (last_s[NUM_FEAT-1]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_sv_q <= NSV_MIN;
      vec_q    <= '0;
    end else begin
      if (accept) vec_q <= fd.vec_in;
      if (idle && fd.cfg_we && fd.cfg_num_sv >= NSV_MIN && fd.cfg_num_sv <= NSV_MAX)
        num_sv_q <= fd.cfg_num_sv;
    end
  end

  // No reset on the SV store: contents survive an aborted classification.
  always_ff @(posedge clk) begin
    if (!rst && idle && fd.sv_we && int'(fd.sv_widx) < NUM_SV_MAX && int'(fd.sv_wfeat) < NUM_FEAT)
      mem_q[fd.sv_widx][fd.sv_wfeat] <= fd.sv_wdata;
  end

  // Skew the slot index rather than the data; memory is frozen while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      actp_q <= '0;
      jp_q   <= '0;
    end else begin
      actp_q[0] <= (state_q == STREAM);
      jp_q[0]   <= j_q;
      for (int i = 1; i < PW; i++) begin
        actp_q[i] <= actp_q[i-1];
        jp_q[i]   <= jp_q[i-1];
      end
    end
  end

  always_comb begin
    act_s    = '0;
    j_s      = '0;
    act_s[0] = (state_q == STREAM);
    j_s[0]   = j_q;
    for (int k = 1; k < NUM_FEAT; k++) begin
      act_s[k] = actp_q[k-1];
      j_s[k]   = jp_q[k-1];
    end
  end

  always_comb begin
    start_s = '0;
    last_s  = '0;
    sv_s    = '0;
    if (!rst) begin
      for (int k = 0; k < NUM_FEAT; k++) begin
        if (act_s[k]) begin
          start_s[k] = (j_s[k] == '0);
          last_s[k]  = ({1'b0, j_s[k]} == last_idx);
          sv_s[k]    = mem_q[j_s[k]][k];
        end
      end
    end
  end

  assign fd.vec_ready       = idle && !rst;
  assign fd.busy            = !idle;
  assign fd.done            = last_s[NUM_FEAT-1];
  assign fd.start_inner     = start_s;
  assign fd.last_inner      = last_s;
  assign fd.sv_out          = sv_s;
  assign fd.curr_vector_out = vec_q;
endmodule
